param_microprocessor: RTL and testbench
=======================================

Name: param_microprocessor

Overview:
- Parametrised, multi-cycle successor to the single-cycle lab microprocessor.
- Generic data width, register count and program depth.
- Explicit FETCH/DECODE/EXECUTE/WRITEBACK FSM; program memory is external, synchronous, 1-cycle read latency.
- Built-in run/step pacing, a debug register read port and status flags for the board display/LED wrapper.

Parameters:
- DATA_W, 6, register/ALU width (>=4).
- ADDR_W, 6, program counter width; program depth = 2**ADDR_W.
- NUM_REGS, 8, register count (power of 2, >=2); REG_W = log2(NUM_REGS).
- TICK_DIV, 50000000, clock cycles per run-mode tick (>=2).
- Derived: IR_W = 3 + 3*REG_W.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- run  in  1  1 = free-run paced by internal tick; 0 = single-step.
- step  in  1  step request, level; rising edge (registered internally) = one instruction.
- instr_addr  out  ADDR_W  program memory address.
- instr_data  in  IR_W  program word; valid the cycle after instr_addr is presented.
- dbg_sel  in  REG_W  register selected for debug read.
- dbg_data  out  DATA_W  combinational read of reg[dbg_sel].
- pc  out  ADDR_W  current program counter.
- ir  out  IR_W  latched instruction.
- alu_out  out  DATA_W  registered ALU result of the last EXECUTE.
- state  out  3  FSM encoding: FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3, HALT=4.
- zero_flag  out  1  last ALU result was 0.
- carry_flag  out  1  carry/borrow of the last ADD/SUB.
- halted  out  1  state==HALT.

Behaviour:
- Reset (reset==0 at a clock edge):
  - pc, ir, alu_out, all registers, flags, tick counter and step edge register -> 0.
  - state -> FETCH.
  - Reset overrides every other input in any state, including mid-instruction.
- Instruction fields: opcode = ir[IR_W-1 -: 3], RA, RB, RD = successive REG_W fields, MSB first.
- go pulse:
  - run=1: go = tick, 1 cycle every TICK_DIV clocks; counter wraps TICK_DIV-1 -> 0.
  - run=0: go = rising edge of step.
  - Counter runs continuously regardless of state; go is consumed only in FETCH, otherwise dropped.
- FETCH: instr_addr = pc. Stay until go; on go -> DECODE.
- DECODE: ir <= instr_data; -> EXECUTE.
- EXECUTE: A = reg[RA], B = reg[RB]; alu_out and flags updated; -> WRITEBACK, or -> HALT for opcode 000.
- Opcodes:
  - 000 HALT: pc not advanced.
  - 001 ADD: RD = A+B mod 2**DATA_W; carry = bit DATA_W.
  - 010 SUB: RD = A-B mod 2**DATA_W; carry = borrow (A<B).
  - 011 AND: RD = A&B; carry = 0.
  - 100 LDI: RD = zero-extended {RA,RB} field (truncated if 2*REG_W > DATA_W); carry = 0.
  - 101 BZ: if A==0, pc <= B[ADDR_W-1:0] (zero-extended if DATA_W<ADDR_W); no register write.
  - 110 JMP: pc <= B[ADDR_W-1:0]; no register write.
  - 111 NOP.
  - For 101/110/111 alu_out = B and flags are unchanged.
- WRITEBACK:
  - Register write for 001-100 only.
  - pc <= branch target if taken, else pc+1, wrapping (2**ADDR_W-1 -> 0).
  - -> FETCH.
- HALT: terminal until reset; go ignored.
- Register writes happen only in WRITEBACK. A write to RD that equals RA/RB never affects the same instruction's operands.
- Minimum latency: 4 cycles per instruction from go.

Optional Feature:
- Macro: PARAM_MICROPROCESSOR_BREAKPOINT_EN.
- When defined, adds inputs bp_enable (1) and bp_addr (ADDR_W), and output bp_hit (1).
  - In FETCH with bp_enable=1 and pc==bp_addr, go is ignored and bp_hit=1.
  - A step rising edge while bp_hit=1 executes that one instruction, even with run=1. bp_hit clears on leaving FETCH.
- When undefined, the ports are absent and FETCH waits only for go.

Test Plan:
- Reset: reset=0 for 2 clocks mid-EXECUTE -> pc=0, state=0, all regs 0, alu_out=0, flags 0, halted=0.
- Step mode, run=0, program LDI r1=5; LDI r2=3; ADD r3=r1+r2; HALT, 4 step pulses:
  - r3=8, carry=0, each instruction takes exactly 4 cycles after its step edge.
  - Stays in HALT (state=4) after further steps.
- Wrap and flags, DATA_W=6: r1=63, r2=1, ADD -> r3=0, zero=1, carry=1. SUB r2-r1 -> 2, carry=1.
- Branches:
  - BZ with reg[RA]=0 and reg[RB]=12 -> pc=12.
  - BZ with reg[RA]=7 -> pc+1.
  - JMP at pc=63 to target 63 -> pc stays 63.
  - NOP at pc=63 -> pc wraps to 0.
- Run mode, TICK_DIV=4 override: run=1 -> one instruction starts every 4 clocks. Step pulses have no effect.
- Breakpoint (macro defined): bp_addr=2 -> stops with pc=2, bp_hit=1. One step -> pc=3 and run resumes.

Source files
------------

// File: rtl/param_microprocessor.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK processor with run/step pacing and debug read port.
// Optional breakpoint logic is enabled with `define PARAM_MICROPROCESSOR_BREAKPOINT_EN.
module param_microprocessor #(
    parameter int DATA_W   = 6,
    parameter int ADDR_W   = 6,
    parameter int NUM_REGS = 8,
    parameter int TICK_DIV = 50000000,
    localparam int REG_W   = $clog2(NUM_REGS),
    localparam int IR_W    = 3 + 3 * REG_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic [IR_W-1:0]   instr_data,
    input  logic [REG_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic [ADDR_W-1:0] pc,
    output logic [IR_W-1:0]   ir,
    output logic [DATA_W-1:0] alu_out,
    output logic [2:0]        state,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic              halted
`ifdef PARAM_MICROPROCESSOR_BREAKPOINT_EN
    ,
    input  logic              bp_enable,
    input  logic [ADDR_W-1:0] bp_addr,
    output logic              bp_hit
`endif
);

    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    localparam logic [2:0] OP_HALT = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_LDI  = 3'd4;
    localparam logic [2:0] OP_BZ   = 3'd5;
    localparam logic [2:0] OP_JMP  = 3'd6;

    state_t            state_r, state_nxt;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [TW-1:0]     tick_cnt;
    logic              step_q;
    logic              tick, step_rise, go, fetch_go;

    logic [2:0]        opcode;
    logic [REG_W-1:0]  ra, rb, rd;
    logic [DATA_W-1:0] a_val, b_val, alu_res;
    logic              alu_c, flag_upd, wr_en, taken;

    assign opcode = ir[IR_W-1 -: 3];
    assign ra     = ir[3*REG_W-1 -: REG_W];
    assign rb     = ir[2*REG_W-1 -: REG_W];
    assign rd     = ir[REG_W-1:0];
    assign a_val  = regs[ra];
    assign b_val  = regs[rb];

    assign dbg_data = regs[dbg_sel];
    assign state    = state_r;

    assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
    assign step_rise = step & ~step_q;
    assign go        = run ? tick : step_rise;

    // A parked breakpoint only yields to a manual step edge, even in run mode.
`ifdef PARAM_MICROPROCESSOR_BREAKPOINT_EN
    assign fetch_go = bp_hit ? step_rise : go;
`else
    assign fetch_go = go;
`endif

    always_ff @(posedge clock) begin
        if (!reset) state_r <= S_FETCH;
        else        state_r <= state_nxt;
    end

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            S_FETCH:     if (fetch_go) state_nxt = S_DECODE;
            S_DECODE:    state_nxt = S_EXECUTE;
            S_EXECUTE:   state_nxt = (opcode == OP_HALT) ? S_HALT : S_WRITEBACK;
            S_WRITEBACK: state_nxt = S_FETCH;
            S_HALT:      state_nxt = S_HALT;
            default:     state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        instr_addr = pc;
        halted     = (state_r == S_HALT);
`ifdef PARAM_MICROPROCESSOR_BREAKPOINT_EN
        bp_hit     = (state_r == S_FETCH) && bp_enable && (pc == bp_addr);
`endif
    end

    // Branches/NOP pass B through so WRITEBACK can take the target from alu_out.
    always_comb begin
        alu_res  = b_val;
        alu_c    = 1'b0;
        flag_upd = 1'b0;
        case (opcode)
            OP_ADD: begin
                {alu_c, alu_res} = {1'b0, a_val} + {1'b0, b_val};
                flag_upd = 1'b1;
            end
            OP_SUB: begin
                alu_res  = a_val - b_val;
                alu_c    = (a_val < b_val);
                flag_upd = 1'b1;
            end
            OP_AND: begin
                alu_res  = a_val & b_val;
                flag_upd = 1'b1;
            end
            OP_LDI: begin
                alu_res  = DATA_W'({ra, rb});
                flag_upd = 1'b1;
            end
            default: ;
        endcase
    end

    assign wr_en = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_LDI);
    assign taken = (opcode == OP_JMP) || ((opcode == OP_BZ) && (a_val == '0));

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc         <= '0;
            ir         <= '0;
            alu_out    <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            step_q     <= 1'b0;
            tick_cnt   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            step_q   <= step;
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            case (state_r)
                S_DECODE: ir <= instr_data;
                S_EXECUTE: begin
                    if (opcode != OP_HALT) alu_out <= alu_res;
                    if (flag_upd) begin
                        zero_flag  <= (alu_res == '0);
                        carry_flag <= alu_c;
                    end
                end
                S_WRITEBACK: begin
                    if (wr_en) regs[rd] <= alu_out;
                    pc <= taken ? ADDR_W'(alu_out) : pc + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_param_microprocessor.sv
// Bench for param_microprocessor: vector table, directed corner sequences and random programs vs an ISA model.
module tb_param_microprocessor;

    localparam int DATA_W = 6;
    localparam int ADDR_W = 6;
    localparam int REG_W  = 3;
    localparam int IR_W   = 12;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              run   = 1'b0;
    logic              step  = 1'b0;
    logic [ADDR_W-1:0] instr_addr;
    logic [IR_W-1:0]   instr_data = '0;
    logic [REG_W-1:0]  dbg_sel    = '0;
    logic [DATA_W-1:0] dbg_data;
    logic [ADDR_W-1:0] pc;
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] alu_out;
    logic [2:0]        state;
    logic              zero_flag, carry_flag, halted;
`ifdef PARAM_MICROPROCESSOR_BREAKPOINT_EN
    logic              bp_enable = 1'b0;
    logic [ADDR_W-1:0] bp_addr   = '0;
    logic              bp_hit;
`endif

    param_microprocessor #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(8), .TICK_DIV(4)) dut (
        .clock(clock), .reset(reset), .run(run), .step(step),
        .instr_addr(instr_addr), .instr_data(instr_data),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data),
        .pc(pc), .ir(ir), .alu_out(alu_out), .state(state),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .halted(halted)
`ifdef PARAM_MICROPROCESSOR_BREAKPOINT_EN
        , .bp_enable(bp_enable), .bp_addr(bp_addr), .bp_hit(bp_hit)
`endif
    );

    always #5 clock = ~clock;

    logic [IR_W-1:0] mem [64];
    always @(posedge clock) instr_data <= mem[instr_addr];

    int n_cmp  = 0;
    int n_fail = 0;

    int m_regs [8];
    int m_pc, m_alu, m_zero, m_carry, m_halt;

    typedef struct {
        int op; int a; int b; int r3; int alu; int z; int c; int pc;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [IR_W-1:0] enc(input int op, input int ra, input int rb, input int rd);
        return {3'(op), 3'(ra), 3'(rb), 3'(rd)};
    endfunction

    function automatic logic [IR_W-1:0] ldi(input int v, input int rd);
        return enc(4, v / 8, v % 8, rd);
    endfunction

    task automatic get_reg(input int i, output int v);
        dbg_sel = 3'(i);
        #1;
        v = int'(dbg_data);
    endtask

    task automatic do_reset();
        @(negedge clock) reset = 1'b0;
        @(negedge clock);
        @(negedge clock) reset = 1'b1;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 64; i++) mem[i] = enc(7, 0, 0, 0);
    endtask

    // One step pulse, then four clocks; optionally checks the per-cycle state walk.
    task automatic step_instr(input bit lat);
        @(negedge clock) step = 1'b1;
        @(negedge clock) step = 1'b0;
        if (lat) chk("lat_decode", int'(state), 1);
        @(negedge clock);
        if (lat) chk("lat_execute", int'(state), 2);
        @(negedge clock);
        if (lat) chk("lat_writeback", int'(state), 3);
        @(negedge clock);
        if (lat) chk("lat_fetch", int'(state), 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_pc = 0; m_alu = 0; m_zero = 0; m_carry = 0; m_halt = 0;
    endtask

    task automatic model_exec();
        int w, op, ra, rb, rd, a, b;
        if (m_halt != 0) return;
        w  = int'(mem[m_pc]);
        op = w / 512; ra = (w / 64) % 8; rb = (w / 8) % 8; rd = w % 8;
        a  = m_regs[ra]; b = m_regs[rb];
        case (op)
            0: m_halt = 1;
            1: begin m_alu = (a + b) % 64; m_carry = (a + b >= 64) ? 1 : 0; end
            2: begin m_alu = (a - b + 64) % 64; m_carry = (a < b) ? 1 : 0; end
            3: begin m_alu = a & b; m_carry = 0; end
            4: begin m_alu = ra * 8 + rb; m_carry = 0; end
            default: m_alu = b;
        endcase
        if (op >= 1 && op <= 4) begin
            m_zero = (m_alu == 0) ? 1 : 0;
            m_regs[rd] = m_alu;
        end
        if (op == 6 || (op == 5 && a == 0)) m_pc = b;
        else if (op != 0) m_pc = (m_pc + 1) % 64;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int v;
        fill_nop();

        // ---------------- reset mid-EXECUTE ----------------
        mem[0] = ldi(63, 1); mem[1] = ldi(1, 2); mem[2] = enc(1, 1, 2, 3); mem[3] = enc(2, 2, 1, 4);
        do_reset();
        chk("reset_initial_state", int'(state), 0);
        step_instr(1); step_instr(1); step_instr(1);
        @(negedge clock) step = 1'b1;
        @(negedge clock) step = 1'b0;
        @(negedge clock);
        chk("pre_reset_execute", int'(state), 2);
        do_reset();
        chk("reset_pc", int'(pc), 0);
        chk("reset_state", int'(state), 0);
        chk("reset_ir", int'(ir), 0);
        chk("reset_alu", int'(alu_out), 0);
        chk("reset_zero", int'(zero_flag), 0);
        chk("reset_carry", int'(carry_flag), 0);
        chk("reset_halted", int'(halted), 0);
        for (int i = 0; i < 8; i++) begin
            get_reg(i, v);
            chk($sformatf("reset_r%0d", i), v, 0);
        end

        // ---------------- vector table ----------------
        vecs[0]  = '{1,  5,  3,  8,  8, 0, 0,  3};
        vecs[1]  = '{1, 63,  1,  0,  0, 1, 1,  3};
        vecs[2]  = '{2,  1, 63,  2,  2, 0, 1,  3};
        vecs[3]  = '{2,  5,  5,  0,  0, 1, 0,  3};
        vecs[4]  = '{3, 42, 15, 10, 10, 0, 0,  3};
        vecs[5]  = '{4,  9,  9, 10, 10, 0, 0,  3};
        vecs[6]  = '{5,  0, 12,  0, 12, 0, 0, 12};
        vecs[7]  = '{5,  7, 12,  0, 12, 0, 0,  3};
        vecs[8]  = '{6,  9, 40,  0, 40, 0, 0, 40};
        vecs[9]  = '{7,  9, 40,  0, 40, 0, 0,  3};
        vecs[10] = '{1,  0,  0,  0,  0, 1, 0,  3};
        vecs[11] = '{2,  0,  1, 63, 63, 0, 1,  3};
        for (int i = 0; i < 12; i++) begin
            fill_nop();
            mem[0] = ldi(vecs[i].a, 1);
            mem[1] = ldi(vecs[i].b, 2);
            mem[2] = enc(vecs[i].op, 1, 2, 3);
            mem[3] = enc(0, 0, 0, 0);
            do_reset();
            step_instr(1); step_instr(1); step_instr(1);
            get_reg(3, v);
            chk($sformatf("vec%0d_r3", i), v, vecs[i].r3);
            chk($sformatf("vec%0d_alu", i), int'(alu_out), vecs[i].alu);
            chk($sformatf("vec%0d_zero", i), int'(zero_flag), vecs[i].z);
            chk($sformatf("vec%0d_carry", i), int'(carry_flag), vecs[i].c);
            chk($sformatf("vec%0d_pc", i), int'(pc), vecs[i].pc);
        end

        // ---------------- step program ending in HALT ----------------
        fill_nop();
        mem[0] = ldi(5, 1); mem[1] = ldi(3, 2); mem[2] = enc(1, 1, 2, 3); mem[3] = enc(0, 0, 0, 0);
        do_reset();
        step_instr(1); step_instr(1); step_instr(1); step_instr(0);
        get_reg(3, v);
        chk("halt_prog_r3", v, 8);
        chk("halt_prog_carry", int'(carry_flag), 0);
        chk("halt_state", int'(state), 4);
        chk("halt_flag", int'(halted), 1);
        chk("halt_pc", int'(pc), 3);
        step_instr(0); step_instr(0);
        chk("halt_sticky_state", int'(state), 4);
        chk("halt_sticky_pc", int'(pc), 3);

        // ---------------- JMP to self at 63, NOP wraps ----------------
        fill_nop();
        mem[0] = ldi(63, 1); mem[1] = enc(6, 0, 1, 0); mem[63] = enc(6, 0, 1, 0);
        do_reset();
        step_instr(1); step_instr(1);
        chk("jmp_to_63", int'(pc), 63);
        step_instr(1);
        chk("jmp_self_63", int'(pc), 63);
        mem[63] = enc(7, 0, 0, 0);
        step_instr(1);
        chk("nop_wrap_pc", int'(pc), 0);

        // ---------------- run mode, one instruction per 4 clocks ----------------
        fill_nop();
        run = 1'b1;
        do_reset();
        begin
            int prev, ndec;
            prev = -1; ndec = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clock);
                step = 1'($urandom_range(0, 1));
                if (state == 3'd1) begin
                    ndec++;
                    if (prev >= 0) chk("run_interval", c - prev, 4);
                    prev = c;
                end
            end
            chk("run_count", ndec, 10);
        end
        step = 1'b0;

`ifdef PARAM_MICROPROCESSOR_BREAKPOINT_EN
        // ---------------- breakpoint ----------------
        bp_enable = 1'b1; bp_addr = 6'd2;
        do_reset();
        for (int i = 0; i < 60 && !bp_hit; i++) @(negedge clock);
        chk("bp_hit_seen", int'(bp_hit), 1);
        chk("bp_pc", int'(pc), 2);
        repeat (12) @(negedge clock);
        chk("bp_parked_pc", int'(pc), 2);
        chk("bp_parked_hit", int'(bp_hit), 1);
        @(negedge clock) step = 1'b1;
        @(negedge clock) step = 1'b0;
        chk("bp_step_decode", int'(state), 1);
        chk("bp_hit_clear", int'(bp_hit), 0);
        repeat (3) @(negedge clock);
        chk("bp_step_pc", int'(pc), 3);
        repeat (12) @(negedge clock);
        chk("bp_run_resumed", (pc > 6'd3) ? 1 : 0, 1);
        bp_enable = 1'b0;
`endif
        run = 1'b0;
        @(negedge clock);

        // ---------------- random programs vs ISA model ----------------
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 64; i++) begin
                logic [IR_W-1:0] w;
                w = IR_W'($urandom);
                if (w[IR_W-1 -: 3] == 3'd0 && $urandom_range(0, 7) != 0) w[IR_W-1 -: 3] = 3'd7;
                mem[i] = w;
            end
            do_reset();
            model_reset();
            for (int k = 0; k < 30; k++) begin
                bit lat;
                lat = (m_halt == 0) && (int'(mem[m_pc]) / 512 != 0);
                step_instr(lat);
                model_exec();
                chk("rnd_pc", int'(pc), m_pc);
                chk("rnd_halted", int'(halted), m_halt);
                chk("rnd_state", int'(state), (m_halt != 0) ? 4 : 0);
                if (m_halt == 0) begin
                    chk("rnd_alu", int'(alu_out), m_alu);
                    chk("rnd_zero", int'(zero_flag), m_zero);
                    chk("rnd_carry", int'(carry_flag), m_carry);
                end
                for (int i = 0; i < 8; i++) begin
                    get_reg(i, v);
                    chk($sformatf("rnd_r%0d", i), v, m_regs[i]);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
